dmem_ctrl: RTL
==============

# dmem_ctrl

Parametrised successor to the single-cycle data memory: a word-organised data RAM with byte, halfword and word loads/stores, sign/zero extension, alignment checking and a configurable wait-state latency exposed through a request/ready handshake. It sits between the processor's memory stage and the data store. The processor stalls until `ready` is high, so a multicycle or pipelined core can model slower memory without changing its datapath.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, 4..4096.
- `LATENCY`, 2: wait-state cycles between accept and completion; 0..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: access request; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `unsgn` in 1: load zero-extends when 1, sign-extends when 0.
- `addr` in 32: byte address.
- `wdata` in 32: store data; the low-order bits are used for byte/half.
- `rdata` out 32: load result; valid while `ready`=1, held until the next completed load.
- `ready` out 1: one-cycle completion pulse.
- `misalign` out 1: one-cycle error pulse, coincident with `ready`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - On `req`=1, latch `we`, `size`, `unsgn`, `addr` and `wdata`.
  - Load the wait counter with `LATENCY`, then go to BUSY.
  - If `req`=0, stay in IDLE.
- BUSY:
  - If counter ≠ 0, decrement it.
  - If counter = 0, perform the access at this clock edge and go to DONE.
- DONE:
  - `ready`=1, and `misalign` is set if the access was flagged.
  - Go to IDLE the next cycle. `req` is ignored in DONE and BUSY.
- Alignment rules:
  - A halfword access requires `addr[0]`=0.
  - A word access requires `addr[1:0]`=00.
  - `size`=11 is always illegal.
  - A flagged access performs no write, and `rdata` keeps its previous value.
- Word index is `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses alias and wrap modulo 4·DEPTH bytes.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k] with k=`addr[1:0]`; halfword h=`addr[1]` occupies [16h+15:16h].
- Stores:
  - A byte store writes only lane k, from `wdata[7:0]`.
  - A halfword store writes its two lanes, from `wdata[15:0]`.
  - A word store writes all lanes.
  - Other lanes are unchanged.
- Loads: the selected byte or halfword is extended to 32 bits per `unsgn`. A word load ignores `unsgn`.
- Memory contents are not reset; they are undefined until written.

## Timing
- Reset values: state IDLE, `ready`=0, `misalign`=0, `rdata`=0, counter=0.
- Accept edge is E0. The access is committed at edge E0+LATENCY+1. `ready` is high during the following cycle.
  - With LATENCY=0, `ready` is high in the cycle after the cycle following accept.
  - Request-to-ready latency is LATENCY+2 cycles, counting the request cycle as cycle 0.
- Throughput: one access per LATENCY+3 cycles. A `req` held high continuously is re-accepted on the first IDLE cycle after DONE.
- `rdata`, `ready` and `misalign` are registered; there is no combinational path from inputs to outputs.
- Input changes after the accept edge have no effect on the in-flight access.
- Reset asserted in BUSY aborts the access: no write occurs and there is no `ready` pulse.
- Reset asserted in DONE clears `ready` immediately; a write committed at the prior edge is retained.
- Boundary cases:
  - LATENCY=15: the counter must not wrap.
  - `addr`=4·DEPTH−1 with a byte access is legal and hits the top lane of the last word.

## Test plan
- Reset, then LATENCY=2: word store 0xDEADBEEF to 0x10, then word load 0x10.
  - Required: `ready` exactly 4 cycles after each request.
  - Required: `rdata`=0xDEADBEEF.
- Byte store 0x80 to 0x13, then byte load 0x13 with `unsgn`=0 and again with `unsgn`=1.
  - Required: rdata 0xFFFFFF80, then 0x00000080.
  - Required: word load 0x10 returns 0x80ADBEEF.
- Halfword store 0x1234 to 0x22, then a halfword load (`unsgn`=0) from 0x22, then from 0x20.
  - Required: rdata 0x00001234 for 0x22.
  - Required: the 0x20 halfword equals the pre-existing low half, unchanged.
- Misaligned word store to 0x11, then word load 0x10.
  - Required: `misalign` and `ready` high together for one cycle.
  - Required: the store has no effect; rdata 0x80ADBEEF.
- Aliasing with DEPTH=64: word store 0x55AA55AA to 0x104, then load 0x004.
  - Required: rdata 0x55AA55AA.
- Reset pulsed during BUSY of a word store 0x0 to 0x10, then load 0x10 after reset.
  - Required: no `ready` pulse for the aborted store.
  - Required: rdata 0x80ADBEEF (memory contents survive reset).
- `req` held high over two back-to-back loads.
  - Required: second accept occurs in the cycle after DONE.
  - Required: `req` in BUSY/DONE is ignored.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Word-organised data RAM with byte/halfword/word access, sign/zero extension,
// alignment checking and a fixed wait-state latency behind a req/ready handshake.
module dmem_ctrl #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_unsgn,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_misalign
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_we;
   logic [1:0]    r_size;
   logic          r_unsgn;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_ready;
   logic          r_misalign;
   logic [31:0]   r_mem [DEPTH];

   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic          w_mis;
   logic          w_commit;
   logic          w_wr;
   logic [3:0]    w_be;
   logic [31:0]   w_wword;
   logic [31:0]   w_rword;
   logic [31:0]   w_merge;
   logic [31:0]   w_shift;
   logic [31:0]   w_load;

   // Upper address bits only alias; they never reach the datapath.
   logic w_unused_addr;
   assign w_unused_addr = ^i_addr[31:AW+2];

   assign w_idx    = r_addr[AW+1:2];
   assign w_lane   = r_addr[1:0];
   assign w_commit = (r_state == StBusy) && (r_cnt == 4'd0);
   assign w_wr     = w_commit && r_we && !w_mis;
   assign w_rword  = r_mem[w_idx];
   assign w_shift  = w_rword >> {w_lane, 3'b000};

   always_comb begin
      w_mis   = 1'b0;
      w_be    = 4'b0000;
      w_wword = r_wdata;
      unique case (r_size)
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_wword = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_mis   = w_lane[0];
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wword = {2{r_wdata[15:0]}};
         end
         2'b10: begin
            w_mis = (w_lane != 2'b00);
            w_be  = 4'b1111;
         end
         default: w_mis = 1'b1;
      endcase
   end

   always_comb begin
      w_merge = w_rword;
      for (int b = 0; b < 4; b++) begin
         if (w_be[b]) w_merge[8*b +: 8] = w_wword[8*b +: 8];
      end
   end

   // A halfword is aligned here, so shifting by the byte lane also selects the right half.
   always_comb begin
      w_load = w_rword;
      unique case (r_size)
         2'b00:   w_load = r_unsgn ? {24'h0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
         2'b01:   w_load = r_unsgn ? {16'h0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
         default: w_load = w_rword;
      endcase
   end

   // Storage is deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[w_idx] <= w_merge;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_cnt      <= 4'd0;
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_unsgn    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_rdata    <= 32'h0;
         r_ready    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               r_ready    <= 1'b0;
               r_misalign <= 1'b0;
               if (i_req) begin
                  r_we    <= i_we;
                  r_size  <= i_size;
                  r_unsgn <= i_unsgn;
                  r_addr  <= i_addr[AW+1:0];
                  r_wdata <= i_wdata;
                  r_cnt   <= 4'(LATENCY);
                  r_state <= StBusy;
               end
            end
            StBusy: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state    <= StDone;
                  r_ready    <= 1'b1;
                  r_misalign <= w_mis;
                  if (!r_we && !w_mis) r_rdata <= w_load;
               end
            end
            StDone: begin
               r_ready    <= 1'b0;
               r_misalign <= 1'b0;
               r_state    <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_rdata    = r_rdata;
   assign o_ready    = r_ready;
   assign o_misalign = r_misalign;

endmodule
